bus_transfer_arbiter: RTL

Arbitrates the shared 32-bit CPU bus between two transfer requesters: the control unit and the I/O/DMA port. Each accepted request is one register-to-register move. The block drives the 5-bit source select of the 32:1 bus multiplexer and a one-hot destination load enable for one cycle, one cycle after acceptance. It also checks that source and destination codes are legal, keeps a sticky error flag, and counts completed transfers.

---
 rtl/bus_transfer_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bus_transfer_arbiter.sv
// bus_transfer_arbiter
// Arbitrates the shared 32-bit CPU bus between the control unit and the
// I/O/DMA port. Each accepted request is one register-to-register move. One
// cycle after acceptance the block drives the bus-mux source select and a
// one-hot destination load enable. It also flags illegal codes in a sticky
// error bit and counts completed transfers with a saturating counter.
//
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN
//   defined   : round-robin between the two requesters when both are valid
//   undefined : fixed priority, ctrl always wins over io
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   ctrl_valid/src/dst/ready control-unit request channel (ready is combinational)
//   io_valid/src/dst/ready   I/O requester channel (ready is combinational)
//   bus_hold                 stall, blocks all grants while high
//   bus_select               registered 5-bit bus-mux select
//   dst_load                 registered one-hot destination load enable
//   xfer_owner               registered owner of the last executed transfer (0 ctrl, 1 io)
//   err, err_clr             sticky illegal-request flag and its clear
//   xfer_count               saturating completed-transfer counter
module bus_transfer_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_valid,
    input  logic [4:0]       ctrl_src,
    input  logic [4:0]       ctrl_dst,
    output logic             ctrl_ready,
    input  logic             io_valid,
    input  logic [4:0]       io_src,
    input  logic [4:0]       io_dst,
    output logic             io_ready,
    input  logic             bus_hold,
    output logic [4:0]       bus_select,
    output logic [23:0]      dst_load,
    output logic             xfer_owner,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int unsigned DST_N = 24;

    // Sources 0-23 are legal.
    function automatic logic src_legal(input logic [4:0] code);
        return code < 5'd24;
    endfunction

    // Writable destinations: R0-R15, HI, LO (0-17), PC (20), MDR (21).
    function automatic logic dst_legal(input logic [4:0] code);
        return (code <= 5'd17) || (code == 5'd20) || (code == 5'd21);
    endfunction

    logic grant_ctrl;
    logic grant_io;
    logic accept;
    logic [4:0] sel_src;
    logic [4:0] sel_dst;
    logic sel_legal;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // High when io won the last contention-free or contended grant's opposite:
    // i.e. io gets priority because ctrl was granted most recently.
    logic io_pri;

    assign grant_ctrl = rst_n && !bus_hold && ctrl_valid && (!io_valid || !io_pri);
    assign grant_io   = rst_n && !bus_hold && io_valid && (!ctrl_valid || io_pri);

    // Pointer moves on every acceptance, legal or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_pri <= 1'b0;
        end else if (grant_ctrl) begin
            io_pri <= 1'b1;
        end else if (grant_io) begin
            io_pri <= 1'b0;
        end
    end
`else
    assign grant_ctrl = rst_n && !bus_hold && ctrl_valid;
    assign grant_io   = rst_n && !bus_hold && io_valid && !ctrl_valid;
`endif

    assign ctrl_ready = grant_ctrl;
    assign io_ready   = grant_io;
    assign accept     = grant_ctrl || grant_io;
    assign sel_src    = grant_io ? io_src : ctrl_src;
    assign sel_dst    = grant_io ? io_dst : ctrl_dst;
    assign sel_legal  = src_legal(sel_src) && dst_legal(sel_dst);

    // Output stage: one-cycle registered execution of the accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_select <= 5'd0;
            dst_load   <= '0;
            xfer_owner <= 1'b0;
            err        <= 1'b0;
            xfer_count <= '0;
        end else begin
            dst_load <= '0;
            if (err_clr) begin
                err <= 1'b0;
            end
            if (accept) begin
                if (sel_legal) begin
                    bus_select <= sel_src;
                    dst_load   <= DST_N'(1) << sel_dst;
                    xfer_owner <= grant_io;
                end else begin
                    // Illegal set overrides a simultaneous clear.
                    err <= 1'b1;
                end
            end
            // A load on the bus this cycle is a completed transfer at this edge.
            if ((dst_load != '0) && (xfer_count != '1)) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

endmodule
